// File: rtl/vita49_pkt_arbiter_if.sv
// vita49_pkt_arbiter_if: stream bundle around the packet arbiter.
// The slave modport is the arbiter's view: it consumes the N_PORTS source
// streams and drives the merged stream. The master modport is the
// surrounding fabric's view: it drives the sources and consumes the merge.
interface vita49_pkt_arbiter_if #(
    parameter int N_PORTS = 2,
    parameter int ID_W    = 3
);
    logic [N_PORTS-1:0]    S_AXIS_TVALID;
    logic [N_PORTS-1:0]    S_AXIS_TREADY;
    logic [64*N_PORTS-1:0] S_AXIS_TDATA;
    logic [N_PORTS-1:0]    S_AXIS_TLAST;
    logic                  M_AXIS_TVALID;
    logic [63:0]           M_AXIS_TDATA;
    logic                  M_AXIS_TLAST;
    logic [ID_W-1:0]       M_AXIS_TID;
    logic                  M_AXIS_TREADY;

    modport slave (
        input  S_AXIS_TVALID, S_AXIS_TDATA, S_AXIS_TLAST, M_AXIS_TREADY,
        output S_AXIS_TREADY, M_AXIS_TVALID, M_AXIS_TDATA, M_AXIS_TLAST, M_AXIS_TID
    );

    modport master (
        output S_AXIS_TVALID, S_AXIS_TDATA, S_AXIS_TLAST, M_AXIS_TREADY,
        input  S_AXIS_TREADY, M_AXIS_TVALID, M_AXIS_TDATA, M_AXIS_TLAST, M_AXIS_TID
    );
endinterface

// File: rtl/vita49_pkt_arbiter.sv
// vita49_pkt_arbiter: packet-granular round-robin merge of N_PORTS 64-bit
// VITA-49 AXI-Stream sources into one registered stream. A grant is locked
// from the first beat to TLAST, and the source index rides on M_AXIS_TID.
// Optional feature: define VITA49_PKT_ARB_STATS_EN to add per-port packet
// counters (pkt_cnt) with a synchronous clear (stats_clr).
module vita49_pkt_arbiter #(
    parameter int N_PORTS = 2,
    parameter int ID_W    = 3
) (
    input  logic                  AXIS_ACLK,
    input  logic                  AXIS_ARESET,
    input  logic                  arb_en,
    vita49_pkt_arbiter_if.slave   axis,
`ifdef VITA49_PKT_ARB_STATS_EN
    input  logic                  stats_clr,
    output logic [32*N_PORTS-1:0] pkt_cnt,
`endif
    output logic                  busy
);
    localparam int DATA_W = 64;

    typedef enum logic {IDLE, PKT} state_t;

    state_t              state;
    logic [ID_W-1:0]     grant;
    logic [ID_W-1:0]     last_grant;
    logic [ID_W-1:0]     next_grant;
    logic                req_found;

    logic                load_ok;
    logic                accept;
    logic                sel_last;
    logic [DATA_W-1:0]   sel_data;
    logic [N_PORTS-1:0]  s_ready;

    logic                vld_p1;
    logic [DATA_W-1:0]   data_p1;
    logic                last_p1;
    logic [ID_W-1:0]     tid_p1;

    // Rotating priority: first requester above last_grant, else wrap to the lowest requester.
    always_comb begin
        req_found  = 1'b0;
        next_grant = last_grant;
        for (int k = 0; k < N_PORTS; k++) begin
            if (!req_found && axis.S_AXIS_TVALID[k] && (ID_W'(k) > last_grant)) begin
                req_found  = 1'b1;
                next_grant = ID_W'(k);
            end
        end
        for (int k = 0; k < N_PORTS; k++) begin
            if (!req_found && axis.S_AXIS_TVALID[k]) begin
                req_found  = 1'b1;
                next_grant = ID_W'(k);
            end
        end
    end

    // Route the granted source to the output register; ready follows downstream ready combinationally.
    always_comb begin
        load_ok  = !vld_p1 || axis.M_AXIS_TREADY;
        s_ready  = '0;
        sel_data = '0;
        sel_last = 1'b0;
        for (int k = 0; k < N_PORTS; k++) begin
            if ((state == PKT) && (grant == ID_W'(k))) begin
                s_ready[k] = load_ok;
                sel_data   = axis.S_AXIS_TDATA[DATA_W*k +: DATA_W];
                sel_last   = axis.S_AXIS_TLAST[k];
            end
        end
        accept = |(axis.S_AXIS_TVALID & s_ready);
    end

    assign axis.S_AXIS_TREADY = s_ready;

    // Grant FSM plus the single output register stage (p1).
    always_ff @(posedge AXIS_ACLK or posedge AXIS_ARESET) begin
        if (AXIS_ARESET) begin
            state      <= IDLE;
            grant      <= '0;
            last_grant <= ID_W'(N_PORTS - 1);
            busy       <= 1'b0;
            vld_p1     <= 1'b0;
            data_p1    <= '0;
            last_p1    <= 1'b0;
            tid_p1     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (arb_en && req_found) begin
                        grant      <= next_grant;
                        last_grant <= next_grant;
                        state      <= PKT;
                        busy       <= 1'b1;
                    end
                end
                PKT: begin
                    if (accept && sel_last) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase

            // ---- stage p1: merged output register ----
            if (accept) begin
                vld_p1  <= 1'b1;
                data_p1 <= sel_data;
                last_p1 <= sel_last;
                tid_p1  <= grant;
            end else if (axis.M_AXIS_TREADY) begin
                vld_p1  <= 1'b0;
            end
        end
    end

    assign axis.M_AXIS_TVALID = vld_p1;
    assign axis.M_AXIS_TDATA  = data_p1;
    assign axis.M_AXIS_TLAST  = last_p1;
    assign axis.M_AXIS_TID    = tid_p1;

`ifdef VITA49_PKT_ARB_STATS_EN
    // Per-port completed-packet counters; clear beats increment, counters wrap.
    always_ff @(posedge AXIS_ACLK or posedge AXIS_ARESET) begin
        if (AXIS_ARESET) begin
            pkt_cnt <= '0;
        end else begin
            for (int k = 0; k < N_PORTS; k++) begin
                if (stats_clr) begin
                    pkt_cnt[32*k +: 32] <= '0;
                end else if (accept && sel_last && (grant == ID_W'(k))) begin
                    pkt_cnt[32*k +: 32] <= pkt_cnt[32*k +: 32] + 32'd1;
                end
            end
        end
    end
`endif
endmodule

// File: tb/tb_vita49_pkt_arbiter.sv
// tb_vita49_pkt_arbiter: randomized self-checking bench for vita49_pkt_arbiter.
// Sources are fed from per-port beat queues; the expected merged stream comes
// from a packet-level round-robin model. Stats checks run when
// VITA49_PKT_ARB_STATS_EN is defined.
module tb_vita49_pkt_arbiter;
    localparam int N_PORTS = 2;
    localparam int ID_W    = 3;

    typedef struct { logic [63:0] d; logic l; } beat_t;
    typedef struct { logic [63:0] d; logic l; logic [ID_W-1:0] tid; int cyc; } obs_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic arb_en = 1'b1;
    logic busy;

    vita49_pkt_arbiter_if #(.N_PORTS(N_PORTS), .ID_W(ID_W)) bus ();

`ifdef VITA49_PKT_ARB_STATS_EN
    logic                  stats_clr = 1'b0;
    logic [32*N_PORTS-1:0] pkt_cnt;
`endif

    vita49_pkt_arbiter #(.N_PORTS(N_PORTS), .ID_W(ID_W)) dut (
        .AXIS_ACLK   (clk),
        .AXIS_ARESET (rst),
        .arb_en      (arb_en),
        .axis        (bus),
`ifdef VITA49_PKT_ARB_STATS_EN
        .stats_clr   (stats_clr),
        .pkt_cnt     (pkt_cnt),
`endif
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int gap_en   = 0;
    int tready_mode = 0;   // 0: always ready, 1: random, 2: stalled

    beat_t src_q [N_PORTS][$];
    beat_t ref_q [N_PORTS][$];
    obs_t  out_q [$];
    obs_t  exp_q [$];
    logic [N_PORTS-1:0] acc;
    logic [N_PORTS-1:0] mid = '0;

    always @(posedge clk) cyc = cyc + 1;

    // Record every transferred output beat.
    always @(negedge clk) begin
        if (!rst && bus.M_AXIS_TVALID && bus.M_AXIS_TREADY)
            out_q.push_back('{bus.M_AXIS_TDATA, bus.M_AXIS_TLAST, bus.M_AXIS_TID, cyc});
    end

    // Source and sink driver: presents queue heads, obeys the AXIS hold rule.
    initial begin
        bit hold;
        bus.S_AXIS_TVALID = '0;
        bus.S_AXIS_TDATA  = '0;
        bus.S_AXIS_TLAST  = '0;
        bus.M_AXIS_TREADY = 1'b1;
        forever begin
            @(negedge clk);
            acc = bus.S_AXIS_TVALID & bus.S_AXIS_TREADY;
            @(posedge clk); #1;
            for (int p = 0; p < N_PORTS; p++) begin
                if (acc[p] && src_q[p].size() > 0) begin
                    mid[p] = !src_q[p][0].l;
                    void'(src_q[p].pop_front());
                end
                hold = bus.S_AXIS_TVALID[p] && !acc[p] && (src_q[p].size() > 0);
                if (src_q[p].size() > 0 &&
                    (hold || gap_en == 0 || !mid[p] || $urandom_range(3) != 0)) begin
                    bus.S_AXIS_TVALID[p]        = 1'b1;
                    bus.S_AXIS_TDATA[64*p +: 64] = src_q[p][0].d;
                    bus.S_AXIS_TLAST[p]         = src_q[p][0].l;
                end else begin
                    bus.S_AXIS_TVALID[p]        = 1'b0;
                    bus.S_AXIS_TDATA[64*p +: 64] = '0;
                    bus.S_AXIS_TLAST[p]         = 1'b0;
                end
            end
            case (tready_mode)
                0:       bus.M_AXIS_TREADY = 1'b1;
                1:       bus.M_AXIS_TREADY = ($urandom_range(3) != 0);
                default: bus.M_AXIS_TREADY = 1'b0;
            endcase
        end
    end

    task automatic clear_srcs();
        for (int p = 0; p < N_PORTS; p++) begin
            src_q[p].delete();
            ref_q[p].delete();
        end
        mid = '0;
    endtask

    task automatic apply_reset();
        @(posedge clk); #1;
        rst = 1'b1; arb_en = 1'b1; gap_en = 0; tready_mode = 0;
        clear_srcs();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        out_q.delete();
    endtask

    task automatic add_beat(input int p, input logic [63:0] d, input logic l);
        beat_t b;
        b.d = d; b.l = l;
        src_q[p].push_back(b);
        ref_q[p].push_back(b);
    endtask

    task automatic add_pkt(input int p, input int len);
        for (int i = 0; i < len; i++) add_beat(p, {$urandom(), $urandom()}, i == len - 1);
    endtask

    // Packet-level reference: whole packets, rotating priority from last winner.
    task automatic build_model();
        int last = N_PORTS - 1;
        int p = 0;
        int pending;
        bit done;
        obs_t o;
        exp_q.delete();
        forever begin
            pending = 0;
            for (int q = 0; q < N_PORTS; q++) pending += ref_q[q].size();
            if (pending == 0) break;
            for (int i = 1; i <= N_PORTS; i++) begin
                p = (last + i) % N_PORTS;
                if (ref_q[p].size() > 0) break;
            end
            last = p;
            done = 1'b0;
            while (!done && ref_q[p].size() > 0) begin
                o.d = ref_q[p][0].d; o.l = ref_q[p][0].l; o.tid = ID_W'(p); o.cyc = 0;
                done = o.l;
                void'(ref_q[p].pop_front());
                exp_q.push_back(o);
            end
        end
    endtask

    task automatic wait_beats(input int n, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (out_q.size() >= n) begin ok = 1'b1; break; end
            @(negedge clk); #2;
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_checks++;
        if (bus.M_AXIS_TVALID !== 1'b0 || bus.M_AXIS_TDATA !== 64'd0 || bus.M_AXIS_TLAST !== 1'b0 ||
            bus.M_AXIS_TID !== '0)
            $display("FAIL reset_m: got v=%b d=%h l=%b tid=%0d expected all zero",
                     bus.M_AXIS_TVALID, bus.M_AXIS_TDATA, bus.M_AXIS_TLAST, bus.M_AXIS_TID);
        else n_pass++;
        n_checks++;
        if (bus.S_AXIS_TREADY !== '0 || busy !== 1'b0)
            $display("FAIL reset_s: got tready=%b busy=%b expected 0/0", bus.S_AXIS_TREADY, busy);
        else n_pass++;
        apply_reset();
        repeat (3) @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || bus.M_AXIS_TVALID !== 1'b0)
            $display("FAIL idle_no_req: got busy=%b v=%b expected 0/0", busy, bus.M_AXIS_TVALID);
        else n_pass++;
    endtask

    task automatic test_single();
        logic        ev [6] = '{0, 0, 1, 1, 1, 0};
        logic        eb [6] = '{0, 1, 1, 1, 0, 0};
        logic [63:0] ed [6] = '{0, 0, 64'h0A, 64'h0B, 64'h0C, 0};
        logic        el [6] = '{0, 0, 0, 0, 1, 0};
        bit seen = 1'b0;
        apply_reset();
        add_beat(0, 64'h0A, 1'b0);
        add_beat(0, 64'h0B, 1'b0);
        add_beat(0, 64'h0C, 1'b1);
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            seen = bus.S_AXIS_TVALID[0];
        end
        n_checks++;
        if (!seen) $display("FAIL single_tvalid: got no source valid expected valid within 10 cycles");
        else n_pass++;
        for (int i = 0; i < 6; i++) begin
            if (i > 0) @(negedge clk);
            n_checks++;
            if (bus.M_AXIS_TVALID !== ev[i] || busy !== eb[i])
                $display("FAIL single_ctl c%0d: got v=%b busy=%b expected v=%b busy=%b",
                         i, bus.M_AXIS_TVALID, busy, ev[i], eb[i]);
            else n_pass++;
            if (ev[i]) begin
                n_checks++;
                if (bus.M_AXIS_TDATA !== ed[i] || bus.M_AXIS_TLAST !== el[i] || bus.M_AXIS_TID !== '0)
                    $display("FAIL single_beat c%0d: got d=%h l=%b tid=%0d expected d=%h l=%b tid=0",
                             i, bus.M_AXIS_TDATA, bus.M_AXIS_TLAST, bus.M_AXIS_TID, ed[i], el[i]);
                else n_pass++;
            end
        end
    endtask

    task automatic test_contention();
        bit ok;
        int gap;
        apply_reset();
        for (int k = 0; k < 4; k++) begin
            add_pkt(0, 4);
            add_pkt(1, 4);
        end
        build_model();
        wait_beats(exp_q.size(), 300, ok);
        repeat (10) @(negedge clk);
        n_checks++;
        if (out_q.size() !== exp_q.size())
            $display("FAIL contention_count: got %0d beats expected %0d", out_q.size(), exp_q.size());
        else n_pass++;
        for (int i = 0; i < exp_q.size() && i < out_q.size(); i++) begin
            n_checks++;
            if (out_q[i].d !== exp_q[i].d || out_q[i].l !== exp_q[i].l || out_q[i].tid !== exp_q[i].tid)
                $display("FAIL contention_beat%0d: got d=%h l=%b tid=%0d expected d=%h l=%b tid=%0d", i,
                         out_q[i].d, out_q[i].l, out_q[i].tid, exp_q[i].d, exp_q[i].l, exp_q[i].tid);
            else n_pass++;
            if (i > 0) begin
                gap = exp_q[i-1].l ? 2 : 1;
                n_checks++;
                if (out_q[i].cyc - out_q[i-1].cyc !== gap)
                    $display("FAIL contention_gap%0d: got %0d cycles expected %0d", i,
                             out_q[i].cyc - out_q[i-1].cyc, gap);
                else n_pass++;
            end
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        bit seen = 1'b0;
        logic [63:0] sd;
        logic sl;
        logic [ID_W-1:0] st;
        apply_reset();
        gap_en = 1; tready_mode = 1;
        for (int k = 0; k < 5; k++) begin
            add_pkt(0, $urandom_range(6, 1));
            add_pkt(1, $urandom_range(6, 1));
        end
        build_model();
        wait_beats(3, 200, ok);
        tready_mode = 2;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            seen = bus.M_AXIS_TVALID && !bus.M_AXIS_TREADY;
        end
        n_checks++;
        if (!seen) $display("FAIL stall_setup: got no stalled valid expected one within 50 cycles");
        else n_pass++;
        sd = bus.M_AXIS_TDATA; sl = bus.M_AXIS_TLAST; st = bus.M_AXIS_TID;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_checks++;
            if (bus.M_AXIS_TVALID !== 1'b1 || bus.M_AXIS_TDATA !== sd || bus.M_AXIS_TLAST !== sl ||
                bus.M_AXIS_TID !== st || bus.S_AXIS_TREADY !== '0)
                $display("FAIL stall_hold%0d: got v=%b d=%h l=%b tid=%0d sready=%b expected v=1 d=%h l=%b tid=%0d sready=0",
                         i, bus.M_AXIS_TVALID, bus.M_AXIS_TDATA, bus.M_AXIS_TLAST, bus.M_AXIS_TID,
                         bus.S_AXIS_TREADY, sd, sl, st);
            else n_pass++;
        end
        tready_mode = 1;
        wait_beats(exp_q.size(), 2000, ok);
        repeat (10) @(negedge clk);
        n_checks++;
        if (out_q.size() !== exp_q.size())
            $display("FAIL bp_count: got %0d beats expected %0d", out_q.size(), exp_q.size());
        else n_pass++;
        for (int i = 0; i < exp_q.size() && i < out_q.size(); i++) begin
            n_checks++;
            if (out_q[i].d !== exp_q[i].d || out_q[i].l !== exp_q[i].l || out_q[i].tid !== exp_q[i].tid)
                $display("FAIL bp_beat%0d: got d=%h l=%b tid=%0d expected d=%h l=%b tid=%0d", i,
                         out_q[i].d, out_q[i].l, out_q[i].tid, exp_q[i].d, exp_q[i].l, exp_q[i].tid);
            else n_pass++;
        end
    endtask

    task automatic test_quiesce();
        bit ok;
        apply_reset();
        add_pkt(0, 8);
        add_pkt(0, 2);
        add_pkt(1, 2);
        build_model();
        wait_beats(2, 100, ok);
        @(posedge clk); #1 arb_en = 1'b0;
        repeat (20) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_checks++;
            if (busy !== 1'b0 || bus.M_AXIS_TVALID !== 1'b0 || bus.S_AXIS_TREADY !== '0)
                $display("FAIL quiesce_idle%0d: got busy=%b v=%b sready=%b expected 0/0/0",
                         i, busy, bus.M_AXIS_TVALID, bus.S_AXIS_TREADY);
            else n_pass++;
        end
        #2;
        n_checks++;
        if (out_q.size() !== 8 || out_q[out_q.size()-1].l !== 1'b1)
            $display("FAIL quiesce_drain: got %0d beats expected 8 ending in TLAST", out_q.size());
        else n_pass++;
        @(posedge clk); #1 arb_en = 1'b1;
        wait_beats(exp_q.size(), 100, ok);
        repeat (5) @(negedge clk);
        n_checks++;
        if (out_q.size() !== exp_q.size())
            $display("FAIL quiesce_count: got %0d beats expected %0d", out_q.size(), exp_q.size());
        else n_pass++;
        for (int i = 0; i < exp_q.size() && i < out_q.size(); i++) begin
            n_checks++;
            if (out_q[i].d !== exp_q[i].d || out_q[i].l !== exp_q[i].l || out_q[i].tid !== exp_q[i].tid)
                $display("FAIL quiesce_beat%0d: got d=%h l=%b tid=%0d expected d=%h l=%b tid=%0d", i,
                         out_q[i].d, out_q[i].l, out_q[i].tid, exp_q[i].d, exp_q[i].l, exp_q[i].tid);
            else n_pass++;
        end
        if (out_q.size() > 8) begin
            n_checks++;
            if (out_q[8].tid !== ID_W'(1))
                $display("FAIL quiesce_resume_tid: got %0d expected 1", out_q[8].tid);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        apply_reset();
        add_pkt(0, 6);
        wait_beats(3, 100, ok);
        rst = 1'b1;
        #1;
        n_checks++;
        if (bus.M_AXIS_TVALID !== 1'b0 || busy !== 1'b0 || bus.S_AXIS_TREADY !== '0)
            $display("FAIL reset_mid_async: got v=%b busy=%b sready=%b expected 0/0/0",
                     bus.M_AXIS_TVALID, busy, bus.S_AXIS_TREADY);
        else n_pass++;
        clear_srcs();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        out_q.delete();
        add_pkt(0, 3);
        add_pkt(1, 3);
        build_model();
        wait_beats(exp_q.size(), 100, ok);
        repeat (5) @(negedge clk);
        n_checks++;
        if (out_q.size() !== exp_q.size() || out_q.size() == 0 || out_q[0].tid !== '0)
            $display("FAIL reset_mid_restart: got %0d beats first tid=%0d expected %0d beats tid=0",
                     out_q.size(), (out_q.size() > 0) ? int'(out_q[0].tid) : -1, exp_q.size());
        else n_pass++;
        for (int i = 0; i < exp_q.size() && i < out_q.size(); i++) begin
            n_checks++;
            if (out_q[i].d !== exp_q[i].d || out_q[i].l !== exp_q[i].l || out_q[i].tid !== exp_q[i].tid)
                $display("FAIL reset_mid_beat%0d: got d=%h l=%b tid=%0d expected d=%h l=%b tid=%0d", i,
                         out_q[i].d, out_q[i].l, out_q[i].tid, exp_q[i].d, exp_q[i].l, exp_q[i].tid);
            else n_pass++;
        end
    endtask

`ifdef VITA49_PKT_ARB_STATS_EN
    task automatic test_stats();
        bit ok;
        bit seen = 1'b0;
        apply_reset();
        for (int k = 0; k < 5; k++) add_pkt(1, $urandom_range(4, 1));
        build_model();
        wait_beats(exp_q.size(), 200, ok);
        repeat (3) @(negedge clk);
        n_checks++;
        if (pkt_cnt[63:32] !== 32'd5 || pkt_cnt[31:0] !== 32'd0)
            $display("FAIL stats_count: got p1=%0d p0=%0d expected 5/0", pkt_cnt[63:32], pkt_cnt[31:0]);
        else n_pass++;
        add_pkt(1, 1);
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = bus.S_AXIS_TVALID[1] && bus.S_AXIS_TREADY[1] && bus.S_AXIS_TLAST[1];
        end
        stats_clr = 1'b1;
        @(posedge clk); #1 stats_clr = 1'b0;
        n_checks++;
        if (!seen || pkt_cnt[63:32] !== 32'd0)
            $display("FAIL stats_clr: got p1=%0d seen=%b expected 0 with accept seen", pkt_cnt[63:32], seen);
        else n_pass++;
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_backpressure();
        test_quiesce();
        test_reset_mid();
`ifdef VITA49_PKT_ARB_STATS_EN
        test_stats();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/vita49_pkt_arbiter.md
Name: vita49_pkt_arbiter

Overview:
- Packet-granular round-robin arbiter that merges N_PORTS independent 64-bit VITA-49 AXI-Stream sources into the single stream feeding the VITA-49 router input.
- A grant is locked from the first beat of a packet until its TLAST beat, so packets are never interleaved.
- The winning port index is carried on M_AXIS_TID.
- A control enable allows software to quiesce the merge cleanly at packet boundaries.

Parameters:
- N_PORTS, 2: number of slave streams, 2..8.
- ID_W, 3: width of M_AXIS_TID; must satisfy 2**ID_W >= N_PORTS.

Ports:
- AXIS_ACLK  in  1  stream clock; all logic is in this single domain.
- AXIS_ARESET  in  1  asynchronous, active-high reset.
- arb_en  in  1  arbitration enable from the control register; level-sensitive.
- S_AXIS_TVALID  in  N_PORTS  per-port valid.
- S_AXIS_TREADY  out  N_PORTS  per-port ready.
- S_AXIS_TDATA  in  64*N_PORTS  per-port data; port k occupies bits [64k+63:64k].
- S_AXIS_TLAST  in  N_PORTS  per-port end of packet.
- M_AXIS_TVALID  out  1  merged valid, registered.
- M_AXIS_TDATA  out  64  merged data, registered.
- M_AXIS_TLAST  out  1  merged last, registered.
- M_AXIS_TID  out  ID_W  source port of the current beat, registered.
- M_AXIS_TREADY  in  1  downstream ready.
- busy  out  1  high while a grant is locked.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - M_AXIS_TVALID=0, M_AXIS_TDATA=0, M_AXIS_TLAST=0, M_AXIS_TID=0.
  - S_AXIS_TREADY=0, busy=0.
  - State=IDLE, last_grant=N_PORTS-1, so port 0 wins first.
- State machine:
  - IDLE: if arb_en=1 and any S_AXIS_TVALID is high, select the first requesting port searching from last_grant+1 upward, modulo N_PORTS. Register it as grant and last_grant. Go to PKT.
  - IDLE: if arb_en=0 or there are no requests, stay in IDLE.
  - PKT: busy=1. Go to IDLE on the cycle an accepted beat from the granted port has S_AXIS_TLAST=1.
- Output stage is a single register:
  - load_ok = !M_AXIS_TVALID || M_AXIS_TREADY.
  - S_AXIS_TREADY[k] = (state==PKT) && (grant==k) && load_ok. This path is combinational from M_AXIS_TREADY. All other ports see 0.
  - Accepted beat (TVALID & TREADY on the granted port): load TDATA, TLAST and TID=grant into the output register; set M_AXIS_TVALID=1.
  - No accepted beat and M_AXIS_TREADY=1: clear M_AXIS_TVALID. Data is don't-care.
  - M_AXIS_TREADY=0 with M_AXIS_TVALID=1: hold all M_AXIS_* outputs stable (AXIS rule).
- Throughput and latency:
  - 1 beat/cycle within a packet.
  - First beat appears on M_AXIS 2 cycles after TVALID rises in IDLE: 1 cycle to arbitrate, 1 cycle through the output register.
  - Exactly one idle arbitration cycle between back-to-back packets.
- Fairness: a port that just finished a packet has lowest priority in the next arbitration. With all ports requesting, grants rotate 0,1,...,N-1,0.
- Boundary conditions:
  - Simultaneous requests in IDLE: resolved by rotating priority only; no fixed preference.
  - arb_en falls during PKT: the current packet completes through TLAST, then the block stays in IDLE. A packet is never truncated.
  - arb_en rises: the next IDLE cycle arbitrates normally.
  - Granted port drops TVALID mid-packet: grant is held and no other port is served. Output bubbles are allowed.
  - Single-beat packet (TVALID and TLAST on the first beat): PKT lasts one accept cycle, then IDLE.
  - Reset mid-packet: the in-flight beat and grant are discarded. After release, arbitration restarts from port 0.
  - TLAST on non-granted ports is ignored.

Optional Feature:
- Macro: VITA49_PKT_ARB_STATS_EN.
- When defined, add output port pkt_cnt (32*N_PORTS bits): one 32-bit counter per port.
  - Counts accepted TLAST beats from that port.
  - Wraps 0xFFFFFFFF to 0.
  - Cleared by reset and by new input port stats_clr (1 bit, synchronous, highest priority over increment).
- When not defined: neither port exists and no counter logic is synthesized.

Test Plan:
- Reset then single request: port 0 sends 3 beats 0x0A..0x0C with TLAST on 0x0C, M_AXIS_TREADY=1 -> M_AXIS shows 0x0A,0x0B,0x0C on consecutive cycles with TID=0, first beat 2 cycles after TVALID, TLAST only on 0x0C, busy falls after the TLAST accept.
- Contention with N_PORTS=2: both ports continuously send 4-beat packets -> TID sequence 0,1,0,1 per packet, no interleaved beats inside a packet, one bubble cycle between packets.
- Backpressure: M_AXIS_TREADY held 0 for 5 cycles mid-packet -> M_AXIS_TDATA/TLAST/TID stable, S_AXIS_TREADY[grant]=0 after the output register fills, no beat lost or duplicated (scoreboard).
- Quiesce: arb_en driven 0 at beat 2 of an 8-beat packet -> all 8 beats delivered, then no grant while requests are pending. arb_en back to 1 -> the other port is granted first.
- Reset mid-packet: assert AXIS_ARESET during beat 3 -> M_AXIS_TVALID=0 immediately (asynchronous). After release, port 0 wins despite last grant being port 0.
- With VITA49_PKT_ARB_STATS_EN: 5 packets on port 1 -> pkt_cnt[63:32]=5. Pulse stats_clr together with a TLAST accept -> counter reads 0.
